// File: rtl/pic_bus_pkg.sv
// Shared types for the 8259 host bus initiator: FSM states, A0 selects and
// command-word bit positions used by the PIC control logic and its benches.
package pic_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_LOW,
    ST_RD_LOW,
    ST_ACK1_LOW,
    ST_ACK_GAP,
    ST_ACK2_LOW,
    ST_RECOVER
  } pic_state_e;

  localparam logic A0_CMD  = 1'b0;
  localparam logic A0_DATA = 1'b1;

  localparam int ICW1_D4   = 4;
  localparam int ICW1_LTIM = 3;
  localparam int ICW1_SNGL = 1;
  localparam int ICW1_IC4  = 0;

  localparam int ICW4_UPM  = 0;

  localparam int OCW2_R    = 7;
  localparam int OCW2_SL   = 6;
  localparam int OCW2_EOI  = 5;

  localparam int OCW3_D3   = 3;
  localparam int OCW3_RR   = 1;
  localparam int OCW3_RIS  = 0;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/int_sync.sv
// Two-flop synchronizer bringing the asynchronous PIC INT line into clk.
module int_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pic_host_master.sv
// Host-side bus initiator for the 8259: times WD/RD strobes for register
// access and runs the two-pulse INTA acknowledge when INT is raised.
//
// state       | meaning
// ST_IDLE     | waiting; acknowledge request beats a pending command
// ST_WR_LOW   | WD low, A0 and data_bus driven
// ST_RD_LOW   | RD low, bus sampled on the last low cycle
// ST_ACK1_LOW | first INTA pulse
// ST_ACK_GAP  | INTA high between the two pulses
// ST_ACK2_LOW | INTA and RD low, vector sampled on the last low cycle
// ST_RECOVER  | all strobes high; write data held on the first cycle
module pic_host_master
  import pic_bus_pkg::*;
#(
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_read,
  input  logic       cmd_a0,
  input  logic [7:0] cmd_data,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  input  logic       ack_en,
  input  logic       INT,
  output logic       vec_valid,
  output logic [7:0] vec_data,
  output logic       ack_busy,
  output logic       WD,
  output logic       RD,
  output logic       INTA,
  output logic       A0,
  inout  wire  [7:0] data_bus
);

  localparam int CW = $clog2(max_int(PULSE_CYCLES, GAP_CYCLES) + 1);
  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CYCLES - 1);

  pic_state_e    state;
  logic [CW-1:0] cnt;
  logic          int_s;
  logic          armed;
  logic          ack_req;
  logic          bus_oe;
  logic [7:0]    bus_q;

  int_sync u_int_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (INT),
    .q     (int_s)
  );

  assign ack_req   = ack_en && int_s && armed;
  assign cmd_ready = (state == ST_IDLE) && !ack_req;
  assign data_bus  = bus_oe ? bus_q : 8'bz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      WD        <= 1'b1;
      RD        <= 1'b1;
      INTA      <= 1'b1;
      A0        <= A0_CMD;
      bus_oe    <= 1'b0;
      bus_q     <= 8'h00;
      rd_valid  <= 1'b0;
      rd_data   <= 8'h00;
      vec_valid <= 1'b0;
      vec_data  <= 8'h00;
      ack_busy  <= 1'b0;
      armed     <= 1'b1;
    end else begin
      rd_valid  <= 1'b0;
      vec_valid <= 1'b0;
      // One acknowledge per INT assertion: re-arm only once INT is seen low.
      if (!int_s) armed <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (ack_req) begin
            state    <= ST_ACK1_LOW;
            cnt      <= PULSE_LOAD;
            INTA     <= 1'b0;
            ack_busy <= 1'b1;
          end else if (cmd_valid) begin
            cnt <= PULSE_LOAD;
            A0  <= cmd_a0;
            if (cmd_read) begin
              state <= ST_RD_LOW;
              RD    <= 1'b0;
            end else begin
              state  <= ST_WR_LOW;
              WD     <= 1'b0;
              bus_oe <= 1'b1;
              bus_q  <= cmd_data;
            end
          end
        end
        ST_WR_LOW: begin
          if (cnt == '0) begin
            state <= ST_RECOVER;
            cnt   <= GAP_LOAD;
            WD    <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_RD_LOW: begin
          if (cnt == '0) begin
            state    <= ST_RECOVER;
            cnt      <= GAP_LOAD;
            RD       <= 1'b1;
            rd_data  <= data_bus;
            rd_valid <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_ACK1_LOW: begin
          if (cnt == '0) begin
            state <= ST_ACK_GAP;
            cnt   <= GAP_LOAD;
            INTA  <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_ACK_GAP: begin
          if (cnt == '0) begin
            state <= ST_ACK2_LOW;
            cnt   <= PULSE_LOAD;
            INTA  <= 1'b0;
            RD    <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_ACK2_LOW: begin
          armed <= 1'b0;
          if (cnt == '0) begin
            state     <= ST_RECOVER;
            cnt       <= GAP_LOAD;
            INTA      <= 1'b1;
            RD        <= 1'b1;
            vec_data  <= data_bus;
            vec_valid <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_RECOVER: begin
          // Write data and A0 stay on the bus for the first cycle as hold time.
          bus_oe <= 1'b0;
          A0     <= A0_CMD;
          if (cnt == '0) begin
            state    <= ST_IDLE;
            ack_busy <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/pic_host_master.md
# pic_host_master

Host-side bus initiator for the 8259 PIC control logic. It turns single-cycle command requests into properly timed `WD`/`RD` strobes with `A0` and `data_bus`, so the PIC can be programmed with ICW1–ICW4 and OCW1–OCW3 and its IRR/ISR can be read back. When the PIC raises `INT`, it runs the two-pulse `INTA` acknowledge sequence and captures the 8-bit vector driven on the second pulse. It sits between the testbench/CPU model and the PIC top level, replacing hand-written strobe stimulus.

## Interface
- `PULSE_CYCLES`, default 2: low time of every `WD`/`RD`/`INTA` strobe, in clocks (≥1).
- `GAP_CYCLES`, default 1: minimum high time between strobes and after each transaction, in clocks (≥1).
- `clk` in 1: single clock; all state changes on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready`.
- `cmd_read` in 1: 1 = bus read, 0 = bus write.
- `cmd_a0` in 1: `A0` value for the command.
- `cmd_data` in 8: write data.
- `rd_valid` out 1: one-cycle pulse; `rd_data` is valid.
- `rd_data` out 8: data captured from `data_bus` on a read.
- `ack_en` in 1: enables automatic `INTA` handling.
- `INT` in 1: interrupt request from PIC.
- `vec_valid` out 1: one-cycle pulse; `vec_data` is valid.
- `vec_data` out 8: vector captured on the second `INTA`.
- `ack_busy` out 1: high while an `INTA` sequence is in progress.
- `WD` out 1: active-low write strobe.
- `RD` out 1: active-low read strobe.
- `INTA` out 1: active-low interrupt acknowledge.
- `A0` out 1: register select.
- `data_bus` inout 8: driven only during write transactions, otherwise Z.

## Operation
- `INT` passes through a 2-flop synchronizer (`int_s`). `ack_req = ack_en && int_s && armed`.
- FSM states: IDLE, WR_LOW, RD_LOW, ACK1_LOW, ACK_GAP, ACK2_LOW, RECOVER. A single down-counter `cnt` times every state except IDLE.
- **IDLE.** `cmd_ready = !ack_req`. If `ack_req`, go to ACK1_LOW; the acknowledge sequence has priority over a pending command. Otherwise, on handshake, latch `cmd_a0`/`cmd_data` and go to WR_LOW or RD_LOW.
- **WR_LOW.** `WD=0`, `A0` = latched value, `data_bus` = latched data, for `PULSE_CYCLES`. Then go to RECOVER.
  - In RECOVER after a write, `data_bus` and `A0` are held for the first cycle (hold time), then `data_bus` returns to Z.
- **RD_LOW.** `RD=0` for `PULSE_CYCLES`. `data_bus` is sampled on the last low cycle into `rd_data`. `rd_valid` pulses in the first RECOVER cycle.
- **ACK1_LOW.** `INTA=0` for `PULSE_CYCLES`. Then ACK_GAP: `INTA=1` for `GAP_CYCLES`.
- **ACK2_LOW.** `INTA=0` and `RD=0` (the PIC drives the vector only while `RD` is low) for `PULSE_CYCLES`. The bus is sampled on the last low cycle into `vec_data`. `vec_valid` pulses in the first RECOVER cycle. `armed` clears.
- **RECOVER.** All strobes high for `GAP_CYCLES`, then IDLE.
- **Re-arm.** `armed` sets when `int_s` is seen low for ≥1 cycle, so there is exactly one acknowledge per `INT` assertion.
- `ack_en` dropping mid-sequence does not abort it; only reset aborts.
- `ack_busy` is high in ACK1_LOW, ACK_GAP, ACK2_LOW, and RECOVER when entered from ACK2_LOW.

## Timing
- Reset values (held while `rst_n`=0, applied asynchronously, including mid-transaction):
  - `WD`=`RD`=`INTA`=1
  - `A0`=0, `data_bus`=Z
  - `cmd_ready`=1, `rd_valid`=`vec_valid`=0
  - `rd_data`=`vec_data`=0, `ack_busy`=0
  - `armed`=1, state=IDLE
- Write: accepted at edge N. `WD` is low on cycles N+1..N+PULSE_CYCLES. `cmd_ready` returns at N+PULSE_CYCLES+GAP_CYCLES+1.
- Read: same strobe timing. `rd_valid` is high at cycle N+PULSE_CYCLES+1.
- Acknowledge: `INT` rising at cycle M gives `INTA` low at M+3 (2 sync + 1 decision).
  - Total sequence = 2·PULSE_CYCLES + GAP_CYCLES.
  - `vec_valid` follows one cycle after the second `INTA` rises.
- `cmd_valid` held while `ack_req` rises in the same cycle: the acknowledge wins. The command is accepted in the first IDLE cycle afterwards, and `cmd_valid` must remain asserted until then.
- Strobes are never low simultaneously, except `INTA`+`RD` in ACK2_LOW.

## Structure
- Shared package `pic_bus_pkg` holds:
  - FSM state enum
  - `A0` select constants
  - ICW1/ICW4/OCW2/OCW3 bit-field localparams (ICW1 D4, LTIM D3, SNGL D1, IC4 D0; OCW3 RR/RIS = D1:D0), shared with the PIC control logic and testbenches.
- Counter width is `$clog2(max(PULSE_CYCLES, GAP_CYCLES)+1)`.
- One sub-module: `int_sync` (2-flop synchronizer).

## Test plan
- Write ICW1=`8'h13` (A0=0), ICW2=`8'h20` (A0=1), ICW4=`8'h01` (A0=1) → three `WD` pulses of 2 cycles each, gaps ≥1, `data_bus` matching on every low cycle, Z otherwise.
- OCW3=`8'h0A` then read with A0=0, PIC IRR=`8'h05` → `rd_valid` one cycle, `rd_data`=`8'h05`.
- Write OCW1=`8'hFE`, then raise IR0 with `ack_en`=1 → `INT` → two `INTA` pulses. `vec_data`=`8'h20`, `vec_valid` for one cycle, no second acknowledge while `INT` stays high.
- `cmd_valid` and `INT` both rising → `INTA` sequence first; write completes afterwards with correct data.
- `rst_n` asserted during `WD` low → `WD`=1 and `data_bus`=Z in the same cycle (asynchronously). After release, `cmd_ready`=1, no `rd_valid`/`vec_valid`.
- `PULSE_CYCLES`=1, `GAP_CYCLES`=3 → strobe widths and recovery times exactly as parameterised.
